// File: rtl/fasthash_pipe_pkg.sv
// Shared widths and types for the hash pipeline drain path.
// Default parameter values and the width helpers used by pipe_drain_fifo.
package fasthash_pipe_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_NPIPE_DEPTH = 3;
    localparam int DEF_FIFO_DEPTH  = 8;

    localparam int PTR_W = $clog2(DEF_FIFO_DEPTH);
    localparam int CNT_W = $clog2(DEF_FIFO_DEPTH + 1);

    typedef logic [DEF_DATA_WIDTH-1:0] data_t;

    // Width needed to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a separate occupancy count.
// Pushes that land on a full FIFO with no pop are dropped and flagged sticky.
module sync_fifo_fwft
    import fasthash_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_FIFO_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    generate
        if ((1 << PW) != DEPTH) begin : g_pow2_chk
            $error("sync_fifo_fwft: DEPTH must be a power of two");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         cnt;
    logic                  ovf;
    logic                  full, pop, wr_en, drop;

    assign full  = (cnt == FULL_CNT);
    assign pop   = (cnt != '0) && out_ready;
    // A pop in the same cycle frees the slot, so a full-FIFO push is still legal then.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (drop) ovf <= 1'b1;
        end
    end

    assign out_valid = (cnt != '0);
    assign out_data  = mem[rd_ptr];
    assign count     = cnt;
    assign overflow  = ovf;

endmodule

// File: rtl/pipe_drain_fifo.sv
// Credit-gated drain for a non-stallable fixed-latency pipeline.
// Credits cover stored plus in-flight words so a stalled consumer never loses data.
module pipe_drain_fifo
    import fasthash_pipe_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int NPIPE_DEPTH = DEF_NPIPE_DEPTH,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                issue_valid,
    output logic                                issue_ready,
    input  logic                                pipe_valid,
    input  logic [DATA_WIDTH-1:0]               pipe_data,
    output logic                                out_valid,
    output logic [DATA_WIDTH-1:0]               out_data,
    input  logic                                out_ready,
    output logic [cnt_width(FIFO_DEPTH)-1:0]    fifo_count,
    output logic                                overflow
);

    localparam int CW = cnt_width(FIFO_DEPTH);
    localparam logic [CW-1:0] MAX_CREDITS = CW'(FIFO_DEPTH);

    generate
        if (FIFO_DEPTH <= NPIPE_DEPTH) begin : g_depth_chk
            $error("pipe_drain_fifo: FIFO_DEPTH must exceed NPIPE_DEPTH");
        end
    endgenerate

    logic [CW-1:0] reserved;
    logic          issue_fire, pop_fire;

    // Evaluated from the registered credit count only, so a same-cycle pop cannot free a credit.
    assign issue_ready = (reserved < MAX_CREDITS);
    assign issue_fire  = issue_valid && issue_ready;
    assign pop_fire    = out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            reserved <= '0;
        end else if (issue_fire && !pop_fire) begin
            reserved <= reserved + 1'b1;
        end else if (!issue_fire && pop_fire) begin
            reserved <= reserved - 1'b1;
        end
    end

    sync_fifo_fwft #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (pipe_valid),
        .push_data (pipe_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (fifo_count),
        .overflow  (overflow)
    );

    a_credit_bound: assert property (@(posedge clock) disable iff (reset)
        reserved <= MAX_CREDITS);
    a_count_le_reserved: assert property (@(posedge clock) disable iff (reset)
        fifo_count <= reserved);

endmodule

// File: tb/tb_pipe_drain_fifo.sv
// Bench for pipe_drain_fifo: an emulated 3-stage pipeline feeds the DUT, and a
// queue-based model of the credit/FIFO rules is compared every cycle.
module tb_pipe_drain_fifo;
    import fasthash_pipe_pkg::*;

    localparam int DW = 32;
    localparam int ND = 3;
    localparam int FD = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          issue_valid = 1'b0;
    logic          issue_ready;
    logic          pipe_valid;
    logic [DW-1:0] pipe_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic [3:0]    fifo_count;
    logic          overflow;

    logic          force_v = 1'b0;
    logic [DW-1:0] force_d = '0;

    int errors = 0;
    int checks = 0;
    bit started = 0;

    always #5 clock = ~clock;

    pipe_drain_fifo #(.DATA_WIDTH(DW), .NPIPE_DEPTH(ND), .FIFO_DEPTH(FD)) dut (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .pipe_valid  (pipe_valid),
        .pipe_data   (pipe_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    // External pipeline: accepted issues carry the running accept count as data.
    int        acc = 0;
    logic [ND-1:0] sr_v = '0;
    data_t     sr_d [ND] = '{default: '0};

    always @(posedge clock) begin
        sr_v    <= {sr_v[ND-2:0], issue_valid && issue_ready};
        sr_d[0] <= data_t'(acc);
        for (int i = 1; i < ND; i++) sr_d[i] <= sr_d[i-1];
        if (reset) acc <= 0;
        else if (issue_valid && issue_ready) acc <= acc + 1;
    end

    assign pipe_valid = sr_v[ND-1] | force_v;
    assign pipe_data  = force_v ? force_d : sr_d[ND-1];

    // Model: a queue of stored words, a credit integer and a sticky error bit.
    data_t mq[$];
    int    mres = 0;
    bit    movf = 0;
    data_t popped[$];

    always @(posedge clock) begin
        bit m_pop;
        bit m_iss;
        if (reset) begin
            mq.delete();
            mres = 0;
            movf = 0;
        end else begin
            m_pop = (mq.size() != 0) && out_ready;
            m_iss = issue_valid && (mres < FD);
            if (m_pop) void'(mq.pop_front());
            if (pipe_valid) begin
                if (mq.size() < FD) mq.push_back(pipe_data);
                else movf = 1;
            end
            mres = mres + int'(m_iss) - int'(m_pop);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (started) begin
            chk("issue_ready", 32'(issue_ready), 32'(mres < FD));
            chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
            chk("overflow", 32'(overflow), 32'(movf));
            if (mq.size() != 0) chk("out_data", out_data, mq[0]);
            if (out_valid && out_ready && !reset) popped.push_back(out_data);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    initial begin
        // Reset and idle
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        started = 1;
        @(negedge clock);
        chk("idle_issue_ready", 32'(issue_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_fifo_count", 32'(fifo_count), 32'd0);
        chk("idle_overflow", 32'(overflow), 32'd0);
        step(1);

        // Steady stream
        out_ready   = 1'b1;
        issue_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("steady_cnt_le1", 32'(fifo_count <= 1), 32'd1);
            chk("steady_ready", 32'(issue_ready), 32'd1);
        end
        issue_valid = 1'b0;
        step(6);
        chk("steady_n", 32'(popped.size()), 32'd10);
        foreach (popped[i]) chk("steady_order", popped[i], 32'(i));
        popped.delete();

        // Reset held mid-traffic
        out_ready   = 1'b0;
        issue_valid = 1'b1;
        step(6);
        chk("pre_reset_cnt", 32'(fifo_count), 32'd3);
        issue_valid = 1'b0;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_issue_ready", 32'(issue_ready), 32'd1);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        step(1);
        popped.delete();

        // Fill with consumer stalled
        issue_valid = 1'b1;
        step(12);
        chk("fill_accepted", 32'(acc), 32'd8);
        chk("fill_ready", 32'(issue_ready), 32'd0);
        chk("fill_count", 32'(fifo_count), 32'd8);
        chk("fill_overflow", 32'(overflow), 32'd0);

        // Issue and pop together at full credit: issue refused, accepted next cycle
        out_ready = 1'b1;
        chk("refuse_ready", 32'(issue_ready), 32'd0);
        step(1);
        out_ready = 1'b0;
        chk("after_pop_ready", 32'(issue_ready), 32'd1);
        chk("after_pop_acc", 32'(acc), 32'd8);
        step(1);
        chk("reaccept_ready", 32'(issue_ready), 32'd0);
        chk("reaccept_acc", 32'(acc), 32'd9);
        issue_valid = 1'b0;
        step(4);
        chk("refill_count", 32'(fifo_count), 32'd8);

        // Rogue word on a full FIFO is dropped
        force_d = 32'hDEADBEEF;
        force_v = 1'b1;
        step(1);
        force_v = 1'b0;
        chk("drop_count", 32'(fifo_count), 32'd8);
        chk("drop_overflow", 32'(overflow), 32'd1);
        step(2);
        chk("sticky_overflow", 32'(overflow), 32'd1);

        out_ready = 1'b1;
        step(10);
        chk("drain_n", 32'(popped.size()), 32'd9);
        foreach (popped[i]) chk("drain_order", popped[i], 32'(i));
        chk("drain_overflow", 32'(overflow), 32'd1);
        chk("drain_ready", 32'(issue_ready), 32'd1);
        chk("drain_count", 32'(fifo_count), 32'd0);

        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("clr_overflow", 32'(overflow), 32'd0);
        popped.delete();

        // Wrap-around with a random consumer
        issue_valid = 1'b1;
        for (int c = 0; c < 400 && popped.size() < 20; c++) begin
            step(1);
            out_ready   = 1'($urandom_range(0, 1));
            issue_valid = (acc < 20);
        end
        issue_valid = 1'b0;
        chk("wrap_n", 32'(popped.size()), 32'd20);
        foreach (popped[i]) chk("wrap_order", popped[i], 32'(i));
        chk("wrap_overflow", 32'(overflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
